sdram_cmd_fsm: RTL and testbench
================================

// Module: sdram_cmd_fsm
// PURPOSE
//  Init and work state machine for the SDRAM controller. Consumes the end_* timing flags, done_200us,
//  ref_domain and sdram_ref_req from sdram_t. Produces the state vectors that sdram_t decodes,
//  sdram_ref_ack, and the registered SDRAM command/address pins. Arbitrates refresh vs write vs read.
// PARAMETERS
//  ROW_W     12      row address width (also sdram_a width)
//  COL_W     9       column address width
//  BA_W      2       bank address width
//  MODE_REG  12'h032 MRS value on sdram_a: CL=3, BL=4, sequential burst
// PORTS
//  clk             in   1   controller clock
//  rst_n           in   1   synchronous active-low reset
//  done_200us      in   1   power-up wait complete (sdram_t)
//  end_trp,end_trfc,end_tmrd,end_trcd,end_tcl,end_tread,end_twait,end_twrite,end_tdal  in  1 each  timing-done flags (sdram_t)
//  ref_domain      in   1   refresh window open; blocks new rd/wr acceptance
//  sdram_ref_req   in   1   refresh request level (sdram_t)
//  sdram_ref_ack   out  1   1-cycle pulse on entry to S_AR
//  sdram_wr_req    in   1   write request level, held until ack
//  sdram_rd_req    in   1   read request level, held until ack
//  sdram_addr      in   BA_W+ROW_W+COL_W  {bank,row,col}; sampled at acceptance
//  sdram_wr_ack    out  1   1-cycle pulse: write accepted
//  sdram_rd_ack    out  1   1-cycle pulse: read accepted
//  init_state      out  5   registered init state
//  work_state      out  5   registered work state
//  cur_init_state  out  5   init_state delayed 1 clk
//  cur_work_state  out  5   work_state delayed 1 clk
//  sdram_cke       out  1   clock enable
//  sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n  out  1 each  command pins
//  sdram_ba        out  BA_W   bank address
//  sdram_a         out  ROW_W  address bus
//  sdram_dq_oe     out  1   DQ drive enable; high exactly while work_state==S_WR_DATA
//  sdram_busy      out  1   high whenever work_state!=S_IDLE or init_state!=I_DONE
// BEHAVIOUR
//  Reset (rst_n low at a clk edge):
//   - init_state=I_POWON, work_state=S_IDLE, cur_* likewise.
//   - Command = NOP (cs,ras,cas,we = 0,1,1,1); cke=1; ba=0; a=0.
//   - All acks, dq_oe = 0; busy = 1.
//   - Reset mid-operation aborts any burst and reruns the full init sequence.
//  Init FSM; each arrow is taken in the cycle after the flag is high; command states last 1 cycle:
//   I_POWON -(done_200us)-> I_PRE -> I_PRE_TRP -(end_trp)-> I_AR0 -> I_AR0_TRFC -(end_trfc)->
//   I_AR1 -> I_AR1_TRFC -(end_trfc)-> I_MRS -> I_MRS_TMRD -(end_tmrd)-> I_DONE (absorbing).
//  Work FSM (runs only when init_state==I_DONE), from S_IDLE, priority order:
//   - sdram_ref_req -> S_AR.
//   - else wr_req && !ref_domain -> S_ACTIVE (write path), sdram_wr_ack=1 in the same cycle.
//   - else rd_req && !ref_domain -> S_ACTIVE (read path), sdram_rd_ack=1 in the same cycle.
//  Write path: S_ACTIVE -> S_TRCD -(end_trcd)-> S_WRITE -> S_WR_DATA -(end_twrite)-> S_TDAL -(end_tdal)-> S_IDLE.
//  Read path:  S_ACTIVE -> S_TRCD -(end_trcd)-> S_READ -> S_CL -(end_tcl)-> S_RD_DATA -(end_tread)-> S_RWAIT -(end_twait)-> S_IDLE.
//  Refresh:    S_AR -> S_TRFC -(end_trfc)-> S_AR1 -> S_TRFC1 -(end_trfc)-> S_IDLE (two back-to-back AREFs).
//  A 1-bit dir register, set at acceptance, selects write or read path after S_TRCD.
//  Commands: decoded from next state and registered, so each command is on the pins exactly while
//  the state equals its command state. All other cycles are NOP.
//   - PRE   0010, a[10]=1 (precharge all)
//   - AREF  0001
//   - MRS   0000, a=MODE_REG, ba=0
//   - ACT   0011, ba/a = latched bank/row
//   - WR    0100 / RD 0101, a = {col zero-extended}, a[10]=1 (auto-precharge), ba = bank
//  Boundaries:
//   - ref_req during init or a burst: held by sdram_t, serviced at the next S_IDLE.
//   - wr_req and rd_req in the same cycle: write wins; read is accepted on a later S_IDLE.
//   - ref_domain high: no acceptance; the request stays pending and no ack is issued.
//   - sdram_addr is ignored outside the acceptance cycle.
// STRUCTURE
//  - Shared include sdram_param.v: I_*/S_* 5-bit encodings, CMD_* 4-bit constants, timing constants.
//  - One sub-module, sdram_cmd_dec: next-state -> {cs_n,ras_n,cas_n,we_n} plus the a[10] rule.
//  - Rest is flat: two state registers, delay registers, address latch, dir bit.
// TESTING (bench pairs this block with sdram_t)
//  1. Release rst_n -> PRE, AREF, AREF, MRS (a=12'h032) in order; I_DONE after end_tmrd; no other non-NOP commands.
//  2. wr_req, addr={2'd1,12'h0A5,9'h010} -> wr_ack 1 cycle; ACT ba=1 a=0A5; WR a=0x410 ba=1; dq_oe for W_BL cycles.
//  3. rd_req and wr_req together at S_IDLE -> write path first; rd_ack at the following S_IDLE; RD a[10]=1.
//  4. ref_req during a read burst -> burst completes; then ref_ack pulse, two AREFs, return to S_IDLE.
//  5. rd_req held while ref_domain=1 -> no ack and pins stay NOP until ref serviced and ref_domain=0.
//  6. rst_n low during S_WR_DATA -> next cycle NOP, dq_oe=0, init_state=I_POWON; init sequence repeats.

Source files
------------

// File: rtl/sdram_cmd_fsm_pkg.sv
// Shared encodings for the SDRAM command FSM: init/work state codes,
// SDRAM command codes {cs_n,ras_n,cas_n,we_n} and nominal timing counts.
package sdram_cmd_fsm_pkg;

    typedef enum logic [4:0] {
        I_POWON    = 5'd0,
        I_PRE      = 5'd1,
        I_PRE_TRP  = 5'd2,
        I_AR0      = 5'd3,
        I_AR0_TRFC = 5'd4,
        I_AR1      = 5'd5,
        I_AR1_TRFC = 5'd6,
        I_MRS      = 5'd7,
        I_MRS_TMRD = 5'd8,
        I_DONE     = 5'd9
    } init_state_t;

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_ACTIVE  = 5'd1,
        S_TRCD    = 5'd2,
        S_WRITE   = 5'd3,
        S_WR_DATA = 5'd4,
        S_TDAL    = 5'd5,
        S_READ    = 5'd6,
        S_CL      = 5'd7,
        S_RD_DATA = 5'd8,
        S_RWAIT   = 5'd9,
        S_AR      = 5'd10,
        S_TRFC    = 5'd11,
        S_AR1     = 5'd12,
        S_TRFC1   = 5'd13
    } work_state_t;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    // Cycles spent in each timed wait state (as counted by the timer block)
    localparam int T_RP   = 2;
    localparam int T_RFC  = 4;
    localparam int T_MRD  = 2;
    localparam int T_RCD  = 2;
    localparam int T_CL   = 3;
    localparam int R_BL   = 4;
    localparam int T_WAIT = 1;
    localparam int W_BL   = 4;
    localparam int T_DAL  = 3;

endpackage

// File: rtl/sdram_cmd_dec.sv
// Next-state to SDRAM command decoder. Init states take precedence until
// the init FSM reaches I_DONE; o_a10 flags commands that force a[10] high
// (precharge-all and auto-precharge on WR/RD).
import sdram_cmd_fsm_pkg::*;

module sdram_cmd_dec (
    input  init_state_t i_init_nxt,
    input  work_state_t i_work_nxt,
    output logic [3:0]  o_cmd,
    output logic        o_a10
);

    // Pure decode of the upcoming state into its command
    always_comb begin
        o_cmd = CMD_NOP;
        o_a10 = 1'b0;
        if (i_init_nxt != I_DONE) begin
            case (i_init_nxt)
                I_PRE:        begin o_cmd = CMD_PRE; o_a10 = 1'b1; end
                I_AR0, I_AR1: o_cmd = CMD_AREF;
                I_MRS:        o_cmd = CMD_MRS;
                default:      ;
            endcase
        end else begin
            case (i_work_nxt)
                S_ACTIVE:   o_cmd = CMD_ACT;
                S_WRITE:    begin o_cmd = CMD_WR; o_a10 = 1'b1; end
                S_READ:     begin o_cmd = CMD_RD; o_a10 = 1'b1; end
                S_AR, S_AR1: o_cmd = CMD_AREF;
                default:    ;
            endcase
        end
    end

endmodule

// File: rtl/sdram_cmd_fsm.sv
// SDRAM init + work state machine. Commands are decoded from the next state
// and registered, so each command sits on the pins exactly while the state
// register holds the matching command state.
import sdram_cmd_fsm_pkg::*;

module sdram_cmd_fsm #(
    parameter int               ROW_W    = 12,
    parameter int               COL_W    = 9,
    parameter int               BA_W     = 2,
    parameter logic [ROW_W-1:0] MODE_REG = 12'h032
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      done_200us,
    input  logic                      end_trp,
    input  logic                      end_trfc,
    input  logic                      end_tmrd,
    input  logic                      end_trcd,
    input  logic                      end_tcl,
    input  logic                      end_tread,
    input  logic                      end_twait,
    input  logic                      end_twrite,
    input  logic                      end_tdal,
    input  logic                      ref_domain,
    input  logic                      sdram_ref_req,
    output logic                      sdram_ref_ack,
    input  logic                      sdram_wr_req,
    input  logic                      sdram_rd_req,
    input  logic [BA_W+ROW_W+COL_W-1:0] sdram_addr,
    output logic                      sdram_wr_ack,
    output logic                      sdram_rd_ack,
    output logic [4:0]                init_state,
    output logic [4:0]                work_state,
    output logic [4:0]                cur_init_state,
    output logic [4:0]                cur_work_state,
    output logic                      sdram_cke,
    output logic                      sdram_cs_n,
    output logic                      sdram_ras_n,
    output logic                      sdram_cas_n,
    output logic                      sdram_we_n,
    output logic [BA_W-1:0]           sdram_ba,
    output logic [ROW_W-1:0]          sdram_a,
    output logic                      sdram_dq_oe,
    output logic                      sdram_busy
);

    localparam int AW = BA_W + ROW_W + COL_W;

    init_state_t          r_init_state, w_init_nxt, r_cur_init;
    work_state_t          r_work_state, w_work_nxt, r_cur_work;
    logic                 w_accept_wr, w_accept_rd;
    logic                 r_dir;          // 1 = write path
    logic [AW-1:0]        r_addr;
    logic [AW-1:0]        w_addr_src;
    logic [3:0]           w_cmd, r_cmd;
    logic                 w_a10;
    logic [BA_W-1:0]      w_ba, r_ba;
    logic [ROW_W-1:0]     w_a, r_a, w_col_ext;
    logic                 r_dq_oe, r_wr_ack, r_rd_ack, r_ref_ack;

    // Next-state logic for both FSMs plus request arbitration at S_IDLE
    always_comb begin
        w_init_nxt  = r_init_state;
        w_work_nxt  = r_work_state;
        w_accept_wr = 1'b0;
        w_accept_rd = 1'b0;
        case (r_init_state)
            I_POWON:    if (done_200us) w_init_nxt = I_PRE;
            I_PRE:      w_init_nxt = I_PRE_TRP;
            I_PRE_TRP:  if (end_trp)  w_init_nxt = I_AR0;
            I_AR0:      w_init_nxt = I_AR0_TRFC;
            I_AR0_TRFC: if (end_trfc) w_init_nxt = I_AR1;
            I_AR1:      w_init_nxt = I_AR1_TRFC;
            I_AR1_TRFC: if (end_trfc) w_init_nxt = I_MRS;
            I_MRS:      w_init_nxt = I_MRS_TMRD;
            I_MRS_TMRD: if (end_tmrd) w_init_nxt = I_DONE;
            default:    ;
        endcase
        if (r_init_state == I_DONE) begin
            case (r_work_state)
                S_IDLE: begin
                    if (sdram_ref_req) begin
                        w_work_nxt = S_AR;
                    end else if (sdram_wr_req && !ref_domain) begin
                        w_work_nxt  = S_ACTIVE;
                        w_accept_wr = 1'b1;
                    end else if (sdram_rd_req && !ref_domain) begin
                        w_work_nxt  = S_ACTIVE;
                        w_accept_rd = 1'b1;
                    end
                end
                S_ACTIVE:  w_work_nxt = S_TRCD;
                S_TRCD:    if (end_trcd) w_work_nxt = r_dir ? S_WRITE : S_READ;
                S_WRITE:   w_work_nxt = S_WR_DATA;
                S_WR_DATA: if (end_twrite) w_work_nxt = S_TDAL;
                S_TDAL:    if (end_tdal) w_work_nxt = S_IDLE;
                S_READ:    w_work_nxt = S_CL;
                S_CL:      if (end_tcl) w_work_nxt = S_RD_DATA;
                S_RD_DATA: if (end_tread) w_work_nxt = S_RWAIT;
                S_RWAIT:   if (end_twait) w_work_nxt = S_IDLE;
                S_AR:      w_work_nxt = S_TRFC;
                S_TRFC:    if (end_trfc) w_work_nxt = S_AR1;
                S_AR1:     w_work_nxt = S_TRFC1;
                S_TRFC1:   if (end_trfc) w_work_nxt = S_IDLE;
                default:   w_work_nxt = S_IDLE;
            endcase
        end
    end

    // State registers and their one-cycle-delayed copies
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_init_state <= I_POWON;
            r_work_state <= S_IDLE;
            r_cur_init   <= I_POWON;
            r_cur_work   <= S_IDLE;
        end else begin
            r_init_state <= w_init_nxt;
            r_work_state <= w_work_nxt;
            r_cur_init   <= r_init_state;
            r_cur_work   <= r_work_state;
        end
    end

    // Latch address and direction only in the acceptance cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_dir  <= 1'b0;
        end else if (w_accept_wr || w_accept_rd) begin
            r_addr <= sdram_addr;
            r_dir  <= w_accept_wr;
        end
    end

    sdram_cmd_dec u_dec (
        .i_init_nxt (w_init_nxt),
        .i_work_nxt (w_work_nxt),
        .o_cmd      (w_cmd),
        .o_a10      (w_a10)
    );

    // ACT is issued in the acceptance cycle itself, before r_addr has the
    // new value, so the live input address is used then.
    assign w_addr_src = (w_accept_wr || w_accept_rd) ? sdram_addr : r_addr;
    assign w_col_ext  = {{(ROW_W-COL_W){1'b0}}, w_addr_src[COL_W-1:0]};

    // Bank/address bus contents for the upcoming command
    always_comb begin
        w_ba = '0;
        w_a  = '0;
        case (w_cmd)
            CMD_MRS: w_a = MODE_REG;
            CMD_ACT: begin
                w_ba = w_addr_src[AW-1 -: BA_W];
                w_a  = w_addr_src[ROW_W+COL_W-1 -: ROW_W];
            end
            CMD_WR, CMD_RD: begin
                w_ba = w_addr_src[AW-1 -: BA_W];
                w_a  = w_col_ext;
            end
            default: ;
        endcase
        if (w_a10) w_a[10] = 1'b1;
    end

    // Registered command pins, data-enable and ack pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd     <= CMD_NOP;
            r_ba      <= '0;
            r_a       <= '0;
            r_dq_oe   <= 1'b0;
            r_wr_ack  <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_ref_ack <= 1'b0;
        end else begin
            r_cmd     <= w_cmd;
            r_ba      <= w_ba;
            r_a       <= w_a;
            r_dq_oe   <= (w_work_nxt == S_WR_DATA);
            r_wr_ack  <= w_accept_wr;
            r_rd_ack  <= w_accept_rd;
            r_ref_ack <= (w_work_nxt == S_AR);
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;
    assign sdram_cke      = 1'b1;
    assign sdram_ba       = r_ba;
    assign sdram_a        = r_a;
    assign sdram_dq_oe    = r_dq_oe;
    assign sdram_wr_ack   = r_wr_ack;
    assign sdram_rd_ack   = r_rd_ack;
    assign sdram_ref_ack  = r_ref_ack;
    assign init_state     = r_init_state;
    assign work_state     = r_work_state;
    assign cur_init_state = r_cur_init;
    assign cur_work_state = r_cur_work;
    assign sdram_busy     = (r_work_state != S_IDLE) || (r_init_state != I_DONE);

endmodule

// File: tb/tb_sdram_cmd_fsm.sv
// Bench for sdram_cmd_fsm: a small timer model stands in for sdram_t, the
// stimulus pushes expected commands into a scoreboard queue and a negedge
// monitor pops/compares whenever the pins carry a command or an ack.
`timescale 1ns/1ps
module tb_sdram_cmd_fsm;
    import sdram_cmd_fsm_pkg::*;

    localparam int ROW_W = 12, COL_W = 9, BA_W = 2, AW = 23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, done_200us = 1'b0;
    logic end_trp = 0, end_trfc = 0, end_tmrd = 0, end_trcd = 0, end_tcl = 0;
    logic end_tread = 0, end_twait = 0, end_twrite = 0, end_tdal = 0;
    logic ref_domain = 0, sdram_ref_req = 0, sdram_wr_req = 0, sdram_rd_req = 0;
    logic [AW-1:0] sdram_addr = '0;
    logic sdram_ref_ack, sdram_wr_ack, sdram_rd_ack;
    logic [4:0] init_state, work_state, cur_init_state, cur_work_state;
    logic sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BA_W-1:0] sdram_ba;
    logic [ROW_W-1:0] sdram_a;
    logic sdram_dq_oe, sdram_busy;

    sdram_cmd_fsm #(.ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W), .MODE_REG(12'h032)) dut (
        .clk(clk), .rst_n(rst_n), .done_200us(done_200us),
        .end_trp(end_trp), .end_trfc(end_trfc), .end_tmrd(end_tmrd), .end_trcd(end_trcd),
        .end_tcl(end_tcl), .end_tread(end_tread), .end_twait(end_twait),
        .end_twrite(end_twrite), .end_tdal(end_tdal),
        .ref_domain(ref_domain), .sdram_ref_req(sdram_ref_req), .sdram_ref_ack(sdram_ref_ack),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req), .sdram_addr(sdram_addr),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .init_state(init_state), .work_state(work_state),
        .cur_init_state(cur_init_state), .cur_work_state(cur_work_state),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
        .sdram_a(sdram_a), .sdram_dq_oe(sdram_dq_oe), .sdram_busy(sdram_busy)
    );

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Timer model: each wait state lasts its nominal number of cycles
    logic [9:0] pkey = '1;
    int fcnt = 0;
    always @(negedge clk) begin
        logic [9:0] k;
        k = {init_state, work_state};
        if (k == pkey) fcnt++; else fcnt = 0;
        pkey = k;
        end_trp    = (init_state == I_PRE_TRP) && fcnt == T_RP-1;
        end_trfc   = ((init_state == I_AR0_TRFC) || (init_state == I_AR1_TRFC) ||
                      (work_state == S_TRFC) || (work_state == S_TRFC1)) && fcnt == T_RFC-1;
        end_tmrd   = (init_state == I_MRS_TMRD) && fcnt == T_MRD-1;
        end_trcd   = (work_state == S_TRCD) && fcnt == T_RCD-1;
        end_tcl    = (work_state == S_CL) && fcnt == T_CL-1;
        end_tread  = (work_state == S_RD_DATA) && fcnt == R_BL-1;
        end_twait  = (work_state == S_RWAIT) && fcnt == T_WAIT-1;
        end_twrite = (work_state == S_WR_DATA) && fcnt == W_BL-1;
        end_tdal   = (work_state == S_TDAL) && fcnt == T_DAL-1;
    end

    // Scoreboard of expected non-NOP pin cycles; ack = {ref,wr,rd}
    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [11:0] a;
        logic [11:0] am;
        logic        bc;
        logic [2:0]  ack;
    } exp_t;
    exp_t sbq[$];

    task automatic push(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                        input logic [11:0] am, input logic bc, input logic [2:0] ack);
        exp_t e;
        e.cmd = c; e.ba = b; e.a = a; e.am = am; e.bc = bc; e.ack = ack;
        sbq.push_back(e);
    endtask

    task automatic push_init();
        push(CMD_PRE,  2'd0, 12'h400, 12'h400, 1'b0, 3'b000);
        push(CMD_AREF, 2'd0, 12'h000, 12'h000, 1'b0, 3'b000);
        push(CMD_AREF, 2'd0, 12'h000, 12'h000, 1'b0, 3'b000);
        push(CMD_MRS,  2'd0, 12'h032, 12'hFFF, 1'b1, 3'b000);
    endtask

    task automatic push_acc(input logic [1:0] b, input logic [11:0] row, input logic [8:0] col,
                            input logic wr);
        push(CMD_ACT, b, row, 12'hFFF, 1'b1, wr ? 3'b010 : 3'b001);
        push(wr ? CMD_WR : CMD_RD, b, {3'b000, col} | 12'h400, 12'hFFF, 1'b1, 3'b000);
    endtask

    task automatic push_ref();
        push(CMD_AREF, 2'd0, 12'h000, 12'h000, 1'b0, 3'b100);
        push(CMD_AREF, 2'd0, 12'h000, 12'h000, 1'b0, 3'b000);
    endtask

    // rst_n as seen by the most recent clock edge
    logic rst_edge = 1'b0;
    always @(posedge clk) rst_edge = rst_n;

    // Monitor: command/ack scoreboard, cur_* delay model, write burst length
    logic [4:0] p_init = 5'd0, p_work = 5'd0;
    bit have_prev = 0;
    int oe_cnt = 0;
    always @(negedge clk) begin
        logic [3:0] c;
        logic [2:0] k;
        exp_t e;
        c = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
        k = {sdram_ref_ack, sdram_wr_ack, sdram_rd_ack};
        if (c != CMD_NOP || k != 3'b000) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_cmd: got cmd=%b ba=%0d a=%h ack=%b, required NOP/no ack",
                         c, sdram_ba, sdram_a, k);
            end else begin
                e = sbq.pop_front();
                if (c !== e.cmd || k !== e.ack || ((sdram_a ^ e.a) & e.am) != 12'h000 ||
                    (e.bc && sdram_ba !== e.ba)) begin
                    n_bad++;
                    $display("FAIL cmd_seq: got cmd=%b ba=%0d a=%h ack=%b, required cmd=%b ba=%0d a=%h(mask %h) ack=%b",
                             c, sdram_ba, sdram_a, k, e.cmd, e.ba, e.a, e.am, e.ack);
                end
            end
        end
        if (have_prev) begin
            chk("cur_init_state", cur_init_state, rst_edge ? p_init : 5'(I_POWON));
            chk("cur_work_state", cur_work_state, rst_edge ? p_work : 5'(S_IDLE));
        end
        p_init = init_state;
        p_work = work_state;
        have_prev = 1;
        if (!rst_edge) oe_cnt = 0;
        else if (sdram_dq_oe) oe_cnt++;
        else if (oe_cnt != 0) begin
            chk("dq_oe_len", oe_cnt, W_BL);
            oe_cnt = 0;
        end
    end

    function automatic logic cond(input int sel);
        case (sel)
            0: return init_state == I_DONE;
            1: return init_state == I_DONE && work_state == S_IDLE;
            2: return sdram_wr_ack;
            3: return sdram_rd_ack;
            4: return sdram_ref_ack;
            5: return work_state == S_WR_DATA;
            6: return work_state == S_RD_DATA;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cond(sel) && n < 400);
        chk({"wait_", nm}, cond(sel), 1);
    endtask

    initial begin
        // 1: reset state and init sequence
        push_init();
        repeat (3) @(negedge clk);
        chk("rst_init_state", init_state, I_POWON);
        chk("rst_work_state", work_state, S_IDLE);
        chk("rst_cmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, CMD_NOP);
        chk("rst_cke", sdram_cke, 1);
        chk("rst_ba_a", {sdram_ba, sdram_a}, 0);
        chk("rst_acks_oe", {sdram_ref_ack, sdram_wr_ack, sdram_rd_ack, sdram_dq_oe}, 0);
        chk("rst_busy", sdram_busy, 1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("wait_200us", init_state, I_POWON);
        done_200us = 1'b1;
        wait_for(0, "init_done");
        chk("busy_idle", sdram_busy, 0);

        // 2: single write
        sdram_addr = {2'd1, 12'h0A5, 9'h010};
        sdram_wr_req = 1'b1;
        push_acc(2'd1, 12'h0A5, 9'h010, 1'b1);
        wait_for(2, "wr_ack");
        sdram_wr_req = 1'b0;
        sdram_addr = '1;
        wait_for(1, "idle_w");

        // 3: write and read together, write wins
        sdram_addr = {2'd2, 12'h3C4, 9'h1FF};
        sdram_wr_req = 1'b1;
        sdram_rd_req = 1'b1;
        push_acc(2'd2, 12'h3C4, 9'h1FF, 1'b1);
        push_acc(2'd3, 12'h001, 9'h055, 1'b0);
        wait_for(2, "wr_ack2");
        sdram_wr_req = 1'b0;
        sdram_addr = {2'd3, 12'h001, 9'h055};
        wait_for(3, "rd_ack");
        sdram_rd_req = 1'b0;
        sdram_addr = '0;
        wait_for(1, "idle_rw");

        // 4: refresh requested mid-read waits for the burst
        sdram_addr = {2'd0, 12'hFFF, 9'h000};
        sdram_rd_req = 1'b1;
        push_acc(2'd0, 12'hFFF, 9'h000, 1'b0);
        wait_for(3, "rd_ack2");
        sdram_rd_req = 1'b0;
        wait_for(6, "rd_data");
        sdram_ref_req = 1'b1;
        push_ref();
        wait_for(4, "ref_ack");
        chk("ref_from_idle", cur_work_state, S_IDLE);
        sdram_ref_req = 1'b0;
        wait_for(1, "idle_ref");

        // 5: ref_domain blocks acceptance
        ref_domain = 1'b1;
        sdram_addr = {2'd1, 12'h123, 9'h0AB};
        sdram_rd_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("dom_no_accept", work_state, S_IDLE);
        sdram_ref_req = 1'b1;
        push_ref();
        wait_for(4, "ref_ack2");
        sdram_ref_req = 1'b0;
        wait_for(1, "idle_ref2");
        repeat (3) @(negedge clk);
        chk("dom_pending", work_state, S_IDLE);
        push_acc(2'd1, 12'h123, 9'h0AB, 1'b0);
        ref_domain = 1'b0;
        wait_for(3, "rd_ack3");
        sdram_rd_req = 1'b0;
        wait_for(1, "idle_dom");

        // 6: reset in the middle of a write burst
        sdram_addr = {2'd2, 12'h456, 9'h004};
        sdram_wr_req = 1'b1;
        push_acc(2'd2, 12'h456, 9'h004, 1'b1);
        wait_for(2, "wr_ack3");
        sdram_wr_req = 1'b0;
        wait_for(5, "wr_data");
        rst_n = 1'b0;
        done_200us = 1'b0;
        @(negedge clk);
        chk("abort_cmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, CMD_NOP);
        chk("abort_dq_oe", sdram_dq_oe, 0);
        chk("abort_init", init_state, I_POWON);
        chk("abort_work", work_state, S_IDLE);
        chk("abort_busy", sdram_busy, 1);
        push_init();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        done_200us = 1'b1;
        wait_for(0, "reinit_done");
        repeat (5) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
